// File: rtl/prog_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Program loader. Receives a byte stream made of a header byte N
//               followed by N little-endian 32-bit words (N = 0 means 128
//               words). For each word it first presents the word address on
//               the shared WriteData bus with the XED strobe, then presents the
//               assembled word with the MemWrite strobe. While a session is
//               active the processor is held off memory via core_hold and the
//               external select lines.
//
//               Optional feature (compile-time macro LOADER_CHECKSUM_EN):
//               one trailing checksum byte is accepted after the last word.
//               err is set when it differs from the XOR of the header and all
//               data bytes. Without the macro there is no checksum state and
//               err is tied low.
//
// Parameters  : Width     - memory data width (at least 32)
//               ADDR_W    - word-address width
//               BASE_WORD - first word address written in every session
//
// Ports       : clk        in   clock, rising edge
//               reset      in   asynchronous reset, active low
//               start      in   begin a session (only looked at in IDLE)
//               s_valid    in   byte-stream valid
//               s_data     in   byte-stream data [7:0]
//               s_ready    out  byte-stream ready
//               IED        out  external write-data select
//               IEA        out  external address select
//               XWE        out  external write-enable select
//               XED        out  address-register load strobe (WriteData[8:2])
//               WriteData  out  shared address/data bus [Width-1:0]
//               MemWrite   out  memory write strobe
//               core_hold  out  processor hold while a session is active
//               busy       out  high in every state except IDLE
//               done       out  one-cycle completion pulse
//               err        out  checksum error flag
//
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int Width     = 32,
    parameter int ADDR_W    = 7,
    parameter int BASE_WORD = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    output logic             s_ready,
    output logic             IED,
    output logic             IEA,
    output logic             XWE,
    output logic             XED,
    output logic [Width-1:0] WriteData,
    output logic             MemWrite,
    output logic             core_hold,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                CNT_W      = 9;
    localparam logic [CNT_W-1:0]  FULL_COUNT = 9'd128;  // header value 0
    localparam logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(BASE_WORD);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HDR     = 3'd1;
    localparam logic [2:0] S_COLLECT = 3'd2;
    localparam logic [2:0] S_ADDR    = 3'd3;
    localparam logic [2:0] S_WRITE   = 3'd4;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK     = 3'd5;
`endif
    localparam logic [2:0] S_DONE    = 3'd6;

    // State that follows the final WRITE of a session.
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_AFTER_LAST = S_CHK;
`else
    localparam logic [2:0] S_AFTER_LAST = S_DONE;
`endif

    // ------------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------------
    logic [2:0]        state_q,    state_d;
    logic              rel_q;                    // set one edge after reset release
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [CNT_W-1:0]  remain_q,   remain_d;
    logic [31:0]       word_q,     word_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [Width-1:0]  wd_q,       wd_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q,     csum_d;
    logic              err_q,      err_d;
`endif

    // Output-decode wires
    logic              w_active;
    logic              w_ready;
    logic              w_xed;
    logic              w_mw;
    logic              w_done;
    logic [Width-1:0]  w_wdata;
    logic              w_start_ok;

    // The first edge after reset release only arms rel_q; start is therefore
    // first honoured on the second edge.
    assign w_start_ok = start & rel_q;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_start_ok) begin
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (s_valid) begin
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (s_valid && (byte_idx_q == 2'd3)) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                // remain_q still counts the word being written this cycle.
                if (remain_q == CNT_W'(1)) begin
                    state_d = S_AFTER_LAST;
                end else begin
                    state_d = S_COLLECT;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (s_valid) begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_active = (state_q != S_IDLE);
        w_ready  = 1'b0;
        w_xed    = 1'b0;
        w_mw     = 1'b0;
        w_done   = 1'b0;
        w_wdata  = wd_q;             // bus holds its last driven value
        case (state_q)
            S_HDR,
            S_COLLECT: begin
                w_ready = 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                w_ready = 1'b1;
            end
`endif
            S_ADDR: begin
                // Byte address of the word: the address register takes [8:2].
                w_xed   = 1'b1;
                w_wdata = Width'({addr_q, 2'b00});
            end
            S_WRITE: begin
                w_mw    = 1'b1;
                w_wdata = Width'(word_q);
            end
            S_DONE: begin
                w_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign s_ready   = w_ready;
    assign IED       = w_active;
    assign IEA       = w_active;
    assign XWE       = w_active;
    assign core_hold = w_active;
    assign busy      = w_active;
    assign XED       = w_xed;
    assign MemWrite  = w_mw;
    assign done      = w_done;
    assign WriteData = w_wdata;

    // ------------------------------------------------------------------------
    // Datapath: next-state values
    // ------------------------------------------------------------------------
    always_comb begin
        byte_idx_d = byte_idx_q;
        remain_d   = remain_q;
        word_d     = word_q;
        addr_d     = addr_q;
        wd_d       = w_wdata;        // capture whatever is on the bus
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (w_start_ok) begin
                    addr_d     = BASE_ADDR;
                    byte_idx_d = 2'd0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = 8'h00;
                    err_d      = 1'b0;
`endif
                end
            end
            S_HDR: begin
                if (s_valid) begin
                    remain_d = (s_data == 8'h00) ? FULL_COUNT : CNT_W'(s_data);
`ifdef LOADER_CHECKSUM_EN
                    csum_d   = s_data;
`endif
                end
            end
            S_COLLECT: begin
                if (s_valid) begin
                    // Little-endian assembly: lane byte_idx receives the byte.
                    word_d[{byte_idx_q, 3'b000} +: 8] = s_data;
                    byte_idx_d = byte_idx_q + 2'd1;   // wraps to lane 0
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ s_data;
`endif
                end
            end
            S_WRITE: begin
                remain_d = remain_q - CNT_W'(1);
                addr_d   = addr_q + ADDR_W'(1);       // modulo 2^ADDR_W
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (s_valid) begin
                    err_d = (s_data != csum_q);
                end
            end
`endif
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rel_q      <= 1'b0;
            byte_idx_q <= 2'd0;
            remain_q   <= '0;
            word_q     <= 32'h0;
            addr_q     <= BASE_ADDR;
            wd_q       <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= 8'h00;
            err_q      <= 1'b0;
`endif
        end else begin
            rel_q      <= 1'b1;
            byte_idx_q <= byte_idx_d;
            remain_q   <= remain_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            wd_q       <= wd_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
            err_q      <= err_d;
`endif
        end
    end

`ifdef LOADER_CHECKSUM_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader. A cycle table covers the
//               single-word session; task-driven sessions cover multi-word
//               streams, address wrap, stalls, ignored start, mid-session
//               reset and (with LOADER_CHECKSUM_EN) the checksum byte.
//               A second instance uses BASE_WORD = 126.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;

    logic        s_ready, IED, IEA, XWE, XED, MemWrite, core_hold, busy, done, err;
    logic [31:0] WriteData;
    logic        s_ready_b, IED_b, IEA_b, XWE_b, XED_b, MemWrite_b;
    logic        core_hold_b, busy_b, done_b, err_b;
    logic [31:0] WriteData_b;

    prog_loader #(.Width(32), .ADDR_W(7), .BASE_WORD(0)) u_dut (
        .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .IED(IED), .IEA(IEA), .XWE(XWE), .XED(XED),
        .WriteData(WriteData), .MemWrite(MemWrite), .core_hold(core_hold),
        .busy(busy), .done(done), .err(err)
    );

    prog_loader #(.Width(32), .ADDR_W(7), .BASE_WORD(126)) u_dut_b (
        .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready_b), .IED(IED_b), .IEA(IEA_b), .XWE(XWE_b), .XED(XED_b),
        .WriteData(WriteData_b), .MemWrite(MemWrite_b), .core_hold(core_hold_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    always #5 clk = ~clk;

    // {s_ready, IED, IEA, XWE, XED, MemWrite, core_hold, busy, done, err, WriteData}
    logic [41:0] obs1;
    assign obs1 = {s_ready, IED, IEA, XWE, XED, MemWrite, core_hold, busy, done, err, WriteData};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Memory model: external address register plus 128-word memory per DUT
    // ------------------------------------------------------------------------
    logic [6:0]  areg1 = 7'd0, areg2 = 7'd0;
    logic [31:0] mem1 [0:127];
    logic [31:0] mem2 [0:127];
    logic [31:0] alog1 [$];
    logic [31:0] alog2 [$];
    int          wr_cnt1 = 0;
    int          viol = 0;
    longint      mw_time = 0;

    always @(negedge clk) begin
        if (XED) begin
            areg1 <= WriteData[8:2];
            alog1.push_back(WriteData);
        end
        if (MemWrite) begin
            mem1[areg1] <= WriteData;
            wr_cnt1     <= wr_cnt1 + 1;
            mw_time     <= $time;
        end
        if (XED_b) begin
            areg2 <= WriteData_b[8:2];
            alog2.push_back(WriteData_b);
        end
        if (MemWrite_b) begin
            mem2[areg2] <= WriteData_b;
        end
        if ((s_ready && (XED || MemWrite)) || (XED && MemWrite) ||
            (s_ready_b && (XED_b || MemWrite_b)) || (XED_b && MemWrite_b)) begin
            viol <= viol + 1;
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (always entered and left on a falling edge)
    // ------------------------------------------------------------------------
    logic [31:0] words [0:127];
    longint      hs_time = 0;
    longint      t_first = 0;

    task automatic send_byte(input logic [7:0] b, input bit gap, input bit pstart);
        bit got;
        if (gap) begin
            s_valid = 1'b0;
            start   = pstart;
            @(negedge clk);
            start   = 1'b0;
        end
        s_valid = 1'b1;
        s_data  = b;
        got     = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            if (s_ready) begin
                got     = 1'b1;
                hs_time = $time;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL byte_accept: byte %h not accepted in 50 cycles, expected acceptance", b);
        end
    endtask

    task automatic run_session(input int n, input bit gap, input bit pstart, input bit bad_cs);
        int          nw;
        logic [7:0]  cs;
        logic [31:0] w;
        bit          found;
        nw = (n == 0) ? 128 : n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cs = n[7:0];
        send_byte(n[7:0], gap, pstart);
        for (int i = 0; i < nw; i++) begin
            w = words[i];
            for (int j = 0; j < 4; j++) begin
                cs = cs ^ w[j*8 +: 8];
                send_byte(w[j*8 +: 8], gap, pstart);
                if (i == 0 && j == 0) t_first = hs_time;
            end
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(bad_cs ? (cs ^ 8'h03) : cs, gap, pstart);
`else
        if (bad_cs) cs = 8'h00;
`endif
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (done) found = 1'b1;
            @(negedge clk);
        end
        check("done_seen", 64'(found), 64'd1);
    endtask

    // ------------------------------------------------------------------------
    // Cycle table for the single-word session
    // ------------------------------------------------------------------------
    typedef struct {
        logic        st;
        logic        vld;
        logic [7:0]  dat;
        logic [41:0] exp;
    } vec_t;

    vec_t vecs [0:11];
    int   nvec = 0;

    function automatic logic [41:0] ex(input logic sr, input logic act, input logic xed,
                                       input logic mw, input logic dn, input logic [31:0] wd);
        return {sr, act, act, act, xed, mw, act, act, dn, 1'b0, wd};
    endfunction

    task automatic add(input logic st, input logic vld, input logic [7:0] dat, input logic [41:0] e);
        vecs[nvec].st  = st;
        vecs[nvec].vld = vld;
        vecs[nvec].dat = dat;
        vecs[nvec].exp = e;
        nvec++;
    endtask

    int base1, base2, wr0;

    initial begin
        // rows: IDLE+start, HDR, 4x COLLECT, ADDR, WRITE, [CHK], DONE, IDLE
        add(1'b1, 1'b0, 8'h00, ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
        add(1'b0, 1'b1, 8'h01, ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
        add(1'b0, 1'b1, 8'hEF, ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
        add(1'b0, 1'b1, 8'hBE, ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
        add(1'b0, 1'b1, 8'hAD, ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
        add(1'b0, 1'b1, 8'hDE, ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
        add(1'b0, 1'b0, 8'h00, ex(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0));
        add(1'b0, 1'b0, 8'h00, ex(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF));
`ifdef LOADER_CHECKSUM_EN
        add(1'b0, 1'b1, 8'h23, ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF));
`endif
        add(1'b0, 1'b0, 8'h00, ex(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF));
        add(1'b0, 1'b0, 8'h00, ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF));

        // ---- reset state and release timing ----
        repeat (2) @(negedge clk);
        check("reset_outputs", 64'(obs1), 64'd0);
        start = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("rel_edge1_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("rel_edge2_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        check("reset_in_hdr", 64'(obs1), 64'd0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // ---- scenario 1: cycle table ----
        for (int i = 0; i < nvec; i++) begin
            start   = vecs[i].st;
            s_valid = vecs[i].vld;
            s_data  = vecs[i].dat;
            #1;
            check($sformatf("s1_row%0d", i), 64'(obs1), 64'(vecs[i].exp));
            @(negedge clk);
        end
        start   = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        check("s1_mem0", 64'(mem1[0]), 64'h0000_0000_DEAD_BEEF);

        // ---- scenario 2/3: three words, s_valid held high ----
        words[0] = 32'h11111111;
        words[1] = 32'h22222222;
        words[2] = 32'h33333333;
        base1 = alog1.size();
        base2 = alog2.size();
        wr0   = wr_cnt1;
        run_session(3, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("s2_writes", 64'(wr_cnt1 - wr0), 64'd3);
        check("s2_addr0", 64'(alog1[base1]),     64'h0);
        check("s2_addr1", 64'(alog1[base1 + 1]), 64'h4);
        check("s2_addr2", 64'(alog1[base1 + 2]), 64'h8);
        check("s2_mem0", 64'(mem1[0]), 64'h11111111);
        check("s2_mem1", 64'(mem1[1]), 64'h22222222);
        check("s2_mem2", 64'(mem1[2]), 64'h33333333);
        // first data byte cycle to last MemWrite cycle, 18 cycles inclusive
        check("s2_latency", 64'((mw_time - t_first) / 10), 64'd17);
        check("s3_addr0", 64'(alog2[base2]),     64'h1F8);
        check("s3_addr1", 64'(alog2[base2 + 1]), 64'h1FC);
        check("s3_addr2", 64'(alog2[base2 + 2]), 64'h0);
        check("s3_mem126", 64'(mem2[126]), 64'h11111111);
        check("s3_mem127", 64'(mem2[127]), 64'h22222222);
        check("s3_mem0",   64'(mem2[0]),   64'h33333333);

        // ---- scenario 4: stalls and start pulses while busy ----
        words[0] = 32'h0D0C0B0A;
        words[1] = 32'h1D1C1B1A;
        words[2] = 32'h2D2C2B2A;
        wr0 = wr_cnt1;
        run_session(3, 1'b1, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("s4_writes", 64'(wr_cnt1 - wr0), 64'd3);
        check("s4_mem0", 64'(mem1[0]), 64'h0D0C0B0A);
        check("s4_mem1", 64'(mem1[1]), 64'h1D1C1B1A);
        check("s4_mem2", 64'(mem1[2]), 64'h2D2C2B2A);
        check("s4_idle_after", 64'(busy), 64'd0);
        check("strobe_rules", 64'(viol), 64'd0);

        // ---- header 0 means 128 words ----
        for (int i = 0; i < 128; i++) words[i] = 32'hC0DE0000 + 32'(i);
        wr0 = wr_cnt1;
        run_session(0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("n0_writes", 64'(wr_cnt1 - wr0), 64'd128);
        check("n0_mem0",   64'(mem1[0]),   64'hC0DE0000);
        check("n0_mem127", 64'(mem1[127]), 64'hC0DE007F);
        check("n0_b_mem126", 64'(mem2[126]), 64'hC0DE0000);
        check("n0_b_mem125", 64'(mem2[125]), 64'hC0DE007F);

        // ---- scenario 5: reset in the middle of word 2 of N=4 ----
        wr0 = wr_cnt1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h04, 1'b0, 1'b0);
        send_byte(8'h5A, 1'b0, 1'b0);
        send_byte(8'h5A, 1'b0, 1'b0);
        send_byte(8'hA5, 1'b0, 1'b0);
        send_byte(8'hA5, 1'b0, 1'b0);
        send_byte(8'h66, 1'b0, 1'b0);
        send_byte(8'h77, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("s5_outputs_zero", 64'(obs1), 64'd0);
        check("s5_b_busy_zero", 64'(busy_b), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("s5_writes", 64'(wr_cnt1 - wr0), 64'd1);
        check("s5_mem0", 64'(mem1[0]), 64'hA5A55A5A);
        check("s5_mem1", 64'(mem1[1]), 64'hC0DE0001);
        words[0] = 32'h12345678;
        run_session(1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("s5_after_mem0", 64'(mem1[0]), 64'h12345678);

`ifdef LOADER_CHECKSUM_EN
        // ---- scenario 6: checksum byte ----
        words[0] = 32'h01020304;
        run_session(1, 1'b0, 1'b0, 1'b0);
        check("s6_err_good", 64'(err), 64'd0);
        run_session(1, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("s6_err_bad", 64'(err), 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
